// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM read port between
// the logo fetcher (requester 0) and the ghost fetcher (requester 1).
// Grants at most one read per cycle, tags each read with its requester id,
// routes returned words back, and keeps per-frame saturating stall counters.
//
// Ports:
//   clk, arst                  pixel clock, async active-high reset
//   frame_sync                 start-of-frame pulse (clears pointer/counters)
//   prio_fixed                 1 = requester 0 always wins, 0 = round-robin
//   reqN_valid/addr/ready      request handshake per requester (ready is comb)
//   rspN_valid/data            registered response per requester
//   rom_addr, rom_en, rom_q    ROM read port (ROM_LAT cycles latency)
//   stallN_cnt                 saturating per-frame stall counters
module sprite_rom_arbiter #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ROM_LAT = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              frame_sync,
  input  logic              prio_fixed,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_q,
  output logic [15:0]       stall0_cnt,
  output logic [15:0]       stall1_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TAG_N = ROM_LAT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              last;      // id of the most recent grant (round-robin pointer)
  logic              gnt_v_c;
  logic              gnt_id_c;
  logic [ADDR_W-1:0] gnt_addr_c;
  logic [TAG_N-1:0]  tag_v;
  logic [TAG_N-1:0]  tag_id;

  // Grant selection; the non-`last` requester wins a round-robin tie
  always_comb begin
    gnt_v_c  = req0_valid | req1_valid;
    gnt_id_c = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id_c = prio_fixed ? 1'b0 : ~last;
    end else if (req1_valid) begin
      gnt_id_c = 1'b1;
    end
    gnt_addr_c = gnt_id_c ? req1_addr : req0_addr;
  end

  assign req0_ready = gnt_v_c & ~gnt_id_c;
  assign req1_ready = gnt_v_c & gnt_id_c;

  // Round-robin pointer; frame_sync overrides a coincident handshake
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      last <= 1'b1;
    end else if (frame_sync) begin
      last <= 1'b1;
    end else if (gnt_v_c) begin
      last <= gnt_id_c;
    end
  end

  // ROM issue register; address holds when idle
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rom_addr <= '0;
      rom_en   <= 1'b0;
    end else begin
      rom_en <= gnt_v_c;
      if (gnt_v_c) begin
        rom_addr <= gnt_addr_c;
      end
    end
  end

  // Tag pipeline: last stage is aligned with the cycle rom_q is valid
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[TAG_N-2:0], gnt_v_c};
      tag_id <= {tag_id[TAG_N-2:0], gnt_id_c};
    end
  end

  // Response routing; data holds its last value between pulses
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= tag_v[TAG_N-1] & ~tag_id[TAG_N-1];
      rsp1_valid <= tag_v[TAG_N-1] & tag_id[TAG_N-1];
      if (tag_v[TAG_N-1] && !tag_id[TAG_N-1]) begin
        rsp0_data <= rom_q;
      end
      if (tag_v[TAG_N-1] && tag_id[TAG_N-1]) begin
        rsp1_data <= rom_q;
      end
    end
  end

  // Saturating stall count; frame_sync clears even over a same-cycle stall
  function automatic logic [CNT_W-1:0] next_stall(input logic [CNT_W-1:0] cnt,
                                                  input logic stall,
                                                  input logic clr);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (clr) begin
      nxt = '0;
    end else if (stall && (cnt != CNT_MAX)) begin
      nxt = cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall0_cnt <= '0;
      stall1_cnt <= '0;
    end else begin
      stall0_cnt <= next_stall(stall0_cnt, req0_valid & ~req0_ready, frame_sync);
      stall1_cnt <= next_stall(stall1_cnt, req1_valid & ~req1_ready, frame_sync);
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed table, hand-written
// sequences, randomized traffic against a queue-based reference model, and
// a long stall-counter saturation run.
module tb_sprite_rom_arbiter;

  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 1;

  logic          clk = 1'b0;
  logic          arst, frame_sync, prio_fixed;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, rom_addr;
  logic          rsp0_valid, rsp1_valid, rom_en;
  logic [DW-1:0] rsp0_data, rsp1_data, rom_q;
  logic [15:0]   stall0_cnt, stall1_cnt;

  always #20 clk = ~clk;

  sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clk(clk), .arst(arst), .frame_sync(frame_sync), .prio_fixed(prio_fixed),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_q(rom_q),
    .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt));

  // ROM contents: 0x0010 holds 0xABCD
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 16'hABDD ^ DW'(a);
  endfunction

  logic [DW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_word(rom_addr);
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending reads are a queue ordered by due cycle
  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } pend_t;
  pend_t q[$];

  int            cyc = 0;
  logic          m_last, m_rom_en;
  logic [AW-1:0] m_rom_addr;
  int            m_st [2];
  logic [DW-1:0] m_rd [2];
  logic          g_v, g_id;
  logic [AW-1:0] cur_a0, cur_a1;

  task automatic model_step();
    logic ev0, ev1;
    logic [AW-1:0] ga;
    if (arst) begin
      m_last = 1'b1; m_rom_en = 1'b0; m_rom_addr = '0;
      m_st[0] = 0; m_st[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
      q.delete();
    end
    g_v  = req0_valid | req1_valid;
    if (req0_valid && req1_valid) g_id = prio_fixed ? 1'b0 : ~m_last;
    else                          g_id = req1_valid;
    ga = g_id ? req1_addr : req0_addr;
    ev0 = 1'b0; ev1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].id) ev1 = 1'b1; else ev0 = 1'b1;
      m_rd[q[0].id] = q[0].data;
      void'(q.pop_front());
    end
    chk("ready0",   32'(req0_ready), 32'(g_v && !g_id));
    chk("ready1",   32'(req1_ready), 32'(g_v && g_id));
    chk("rom_en",   32'(rom_en),     32'(m_rom_en));
    chk("rom_addr", 32'(rom_addr),   32'(m_rom_addr));
    chk("stall0",   32'(stall0_cnt), 32'(m_st[0]));
    chk("stall1",   32'(stall1_cnt), 32'(m_st[1]));
    chk("rsp0_v",   32'(rsp0_valid), 32'(ev0));
    chk("rsp1_v",   32'(rsp1_valid), 32'(ev1));
    chk("rsp0_d",   32'(rsp0_data),  32'(m_rd[0]));
    chk("rsp1_d",   32'(rsp1_data),  32'(m_rd[1]));
    if (!arst) begin
      if (g_v) q.push_back('{id: g_id, data: rom_word(ga), due: cyc + 2 + int'(LAT)});
      m_rom_en = g_v;
      if (g_v) m_rom_addr = ga;
      if (req0_valid && !(g_v && !g_id)) m_st[0] = (m_st[0] < 65535) ? m_st[0] + 1 : 65535;
      if (req1_valid && !(g_v && g_id))  m_st[1] = (m_st[1] < 65535) ? m_st[1] + 1 : 65535;
      if (frame_sync) begin
        m_st[0] = 0; m_st[1] = 0; m_last = 1'b1;
      end else if (g_v) begin
        m_last = g_id;
      end
    end
    cyc++;
  endtask

  // One clock cycle: drive after the edge, check at the falling edge
  task automatic cycle(input bit rst, input bit fs, input bit pf,
                       input bit v0, input bit v1, input bit rnd);
    @(posedge clk); #1;
    arst = rst; frame_sync = fs; prio_fixed = pf;
    req0_valid = v0; req1_valid = v1;
    req0_addr = cur_a0; req1_addr = cur_a1;
    @(negedge clk);
    model_step();
    if (g_v && !rst) begin
      if (!g_id) cur_a0 = rnd ? AW'($urandom) : cur_a0 + AW'(1);
      else       cur_a1 = rnd ? AW'($urandom) : cur_a1 + AW'(1);
    end
  endtask

  typedef struct {
    bit rst, fs, pf, v0, v1, r0, r1;
    logic [15:0] s0, s1;
  } vec_t;
  vec_t vt[$];

  task automatic addv(input bit rst, input bit fs, input bit pf, input bit v0, input bit v1,
                      input bit r0, input bit r1, input int s0, input int s1);
    vt.push_back('{rst: rst, fs: fs, pf: pf, v0: v0, v1: v1, r0: r0, r1: r1,
                   s0: 16'(s0), s1: 16'(s1)});
  endtask

  bit h0, h1, v0r, v1r;

  initial begin
    arst = 1'b1; frame_sync = 1'b0; prio_fixed = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    cur_a0 = AW'(16'h0100); cur_a1 = AW'(16'h2200);
    req0_addr = cur_a0; req1_addr = cur_a1;

    // reset, ready during reset
    addv(1,0,0,0,0, 0,0, 0,0);
    addv(1,0,0,1,1, 1,0, 0,0);
    // round-robin contention: 8 cycles
    addv(0,0,0,1,1, 1,0, 0,0);  addv(0,0,0,1,1, 0,1, 0,1);
    addv(0,0,0,1,1, 1,0, 1,1);  addv(0,0,0,1,1, 0,1, 1,2);
    addv(0,0,0,1,1, 1,0, 2,2);  addv(0,0,0,1,1, 0,1, 2,3);
    addv(0,0,0,1,1, 1,0, 3,3);  addv(0,0,0,1,1, 0,1, 3,4);
    addv(0,1,0,0,0, 0,0, 4,4);
    // fixed priority: 6 cycles, then req0 drops
    for (int i = 0; i < 6; i++) addv(0,0,1,1,1, 1,0, 0,i);
    addv(0,0,1,0,1, 0,1, 0,6);
    addv(0,0,0,0,0, 0,0, 0,6);
    // frame_sync coinciding with a tie
    addv(0,0,0,1,1, 1,0, 0,6);
    addv(0,1,0,1,1, 0,1, 0,7);
    addv(0,0,0,1,1, 1,0, 0,0);
    addv(0,0,0,0,0, 0,0, 0,1);
    // reset while a req1 read is in flight
    addv(0,0,0,0,1, 0,1, 0,1);
    addv(1,0,0,0,0, 0,0, 0,0);  addv(1,0,0,0,0, 0,0, 0,0);
    addv(1,0,0,0,0, 0,0, 0,0);
    addv(0,0,0,1,1, 1,0, 0,0);
    for (int i = 0; i < 4; i++) addv(0,0,0,0,0, 0,0, 0,1);

    foreach (vt[i]) begin
      cycle(vt[i].rst, vt[i].fs, vt[i].pf, vt[i].v0, vt[i].v1, 1'b0);
      chk("tbl_r0", 32'(req0_ready), 32'(vt[i].r0));
      chk("tbl_r1", 32'(req1_ready), 32'(vt[i].r1));
      chk("tbl_s0", 32'(stall0_cnt), 32'(vt[i].s0));
      chk("tbl_s1", 32'(stall1_cnt), 32'(vt[i].s1));
    end

    // single requester latency
    cycle(1,0,0,0,0,0);
    cur_a0 = AW'(16'h0010);
    for (int k = 0; k <= 8; k++) begin
      cycle(0,0,0, k == 5, 0, 0);
      if (k == 5) chk("single_ready0", 32'(req0_ready), 32'(1));
      if (k == 6) begin
        chk("single_rom_addr", 32'(rom_addr), 32'(16'h0010));
        chk("single_rom_en",   32'(rom_en),   32'(1));
      end
      if (k == 8) begin
        chk("single_rsp0_v", 32'(rsp0_valid), 32'(1));
        chk("single_rsp0_d", 32'(rsp0_data),  32'(16'hABCD));
        chk("single_rsp1_v", 32'(rsp1_valid), 32'(0));
      end
    end

    // randomized traffic; requesters hold address while stalled
    h0 = 1'b0; h1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      v0r = h0 || ($urandom_range(0, 9) < 6);
      v1r = h1 || ($urandom_range(0, 9) < 6);
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 3) == 0, v0r, v1r, 1'b1);
      h0 = v0r && !(g_v && !g_id);
      h1 = v1r && !(g_v && g_id);
    end
    for (int i = 0; i < 4; i++) cycle(0,0,0,0,0,0);

    // stall counter saturation
    cycle(0,1,1,0,0,0);
    for (int i = 0; i < 70000; i++) cycle(0,0,1,1,1,0);
    chk("sat_stall1", 32'(stall1_cnt), 32'(16'hFFFF));
    chk("sat_stall0", 32'(stall0_cnt), 32'(0));
    for (int i = 0; i < 4; i++) cycle(0,0,0,0,0,0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
